// File: rtl/switch_debounce4.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce4
// Brief    : Two-flop synchroniser and independent counter debounce for four
//            slide switches, with registered levels and one-cycle change pulses.
// Revision : 1.0  initial release
// ============================================================================
module switch_debounce4 #(
   parameter int CNT_MAX = 240000,
   parameter int CNT_W   = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic [3:0] chg,
   output logic       any_chg
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CNT_MAX - 1);

   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_stable;
   logic [3:0] w_chg;
   logic [3:0] w_accept;
   logic       r_any_chg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 4'b0000;
         r_sync2 <= 4'b0000;
      end else begin
         r_sync1 <= sw_in;
         r_sync2 <= r_sync1;
      end
   end

   // The counter only ever advances on a mismatch, so a new level is taken
   // after exactly CNT_MAX consecutive disagreeing samples of sync2.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_bit
         logic [CNT_W-1:0] r_cnt;
         logic             r_stb;
         logic             r_pulse;
         logic             w_mismatch;

         assign w_mismatch  = r_sync2[i] ^ r_stb;
         assign w_accept[i] = w_mismatch && (r_cnt == c_cnt_last);
         assign w_stable[i] = r_stb;
         assign w_chg[i]    = r_pulse;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt   <= '0;
               r_stb   <= 1'b0;
               r_pulse <= 1'b0;
            end else if (!w_mismatch) begin
               r_cnt   <= '0;
               r_pulse <= 1'b0;
            end else if (w_accept[i]) begin
               r_cnt   <= '0;
               r_stb   <= r_sync2[i];
               r_pulse <= 1'b1;
            end else begin
               r_cnt   <= r_cnt + CNT_W'(1);
               r_pulse <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_any_chg <= 1'b0;
      end else begin
         r_any_chg <= |w_accept;
      end
   end

   assign a       = w_stable[3];
   assign b       = w_stable[2];
   assign c       = w_stable[1];
   assign d       = w_stable[0];
   assign chg     = w_chg;
   assign any_chg = r_any_chg;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce4.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce4
// Brief    : Directed and randomised bench for switch_debounce4 (CNT_MAX = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_switch_debounce4;

   localparam int CNT_MAX = 4;
   localparam int CNT_W   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sw_in = 4'b0000;
   logic       a, b, c, d;
   logic [3:0] chg;
   logic       any_chg;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;
   int n_chg1 = 0;
   int n_any  = 0;

   // reference state: accepted levels and pulses after the latest edge
   bit [3:0] m_stable = 4'b0000;
   bit [3:0] m_chg    = 4'b0000;
   bit       m_any    = 1'b0;
   bit [3:0] raw_q[$];
   bit [3:0] win_q[$];

   switch_debounce4 #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw_in   (sw_in),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .chg     (chg),
      .any_chg (any_chg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   // A level is accepted when the last CNT_MAX synchronised samples all
   // disagree with the current level; samples reach sync2 two edges late.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_stable = 4'b0000;
         m_chg    = 4'b0000;
         m_any    = 1'b0;
         raw_q.delete();
         win_q.delete();
         raw_q.push_back(4'b0000);
         raw_q.push_back(4'b0000);
         for (int k = 0; k < CNT_MAX; k++) win_q.push_back(4'b0000);
      end else begin
         bit [3:0] s;
         bit [3:0] acc;
         s = raw_q[1];
         raw_q.push_front(sw_in);
         void'(raw_q.pop_back());
         win_q.push_front(s);
         void'(win_q.pop_back());
         acc = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            foreach (win_q[k]) if (win_q[k][i] == m_stable[i]) all_diff = 1'b0;
            acc[i] = all_diff;
         end
         m_stable = m_stable ^ acc;
         m_chg    = acc;
         m_any    = |acc;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) chk("model", {a, b, c, d, chg, any_chg}, {m_stable, m_chg, m_any});
      if (chg[1]) n_chg1++;
      if (any_chg) n_any++;
   end

   task automatic apply(input logic [3:0] v);
      @(posedge clk);
      #2 sw_in = v;
   endtask

   task automatic wait_edge(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] prev;
      int         n0;
      int         exp_any;
      bit [1:0]   bseq [6];

      bseq = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};

      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_state", {a, b, c, d, chg, any_chg}, 9'b0);

      wait_edge(20);
      chk("idle_zero", {a, b, c, d, chg, any_chg}, 9'b0);

      // clean step on a
      apply(4'b1000);
      wait_edge(5);
      chk("step_before", {a, b, c, d, chg, any_chg}, 9'b0000_0000_0);
      wait_edge(1);
      chk("step_accept", {a, b, c, d, chg, any_chg}, 9'b1000_1000_1);
      wait_edge(1);
      chk("step_pulse_end", {a, b, c, d, chg, any_chg}, 9'b1000_0000_0);

      // 3-cycle glitch on d is rejected, then a clean high is taken
      apply(4'b1001);
      repeat (2) @(posedge clk);
      apply(4'b1000);
      wait_edge(10);
      chk("glitch_reject", {a, b, c, d}, 9'b1000);
      apply(4'b1001);
      wait_edge(5);
      chk("d_rise_before", {a, b, c, d}, 9'b1000);
      wait_edge(1);
      chk("d_rise", {a, b, c, d, chg}, 9'b1001_0001);
      wait_edge(4);

      // bounce on c
      n0 = n_chg1;
      for (int k = 0; k < 6; k++) apply(4'b1001 | {1'b0, bseq[k][0], 1'b0, 1'b0} >> 1);
      wait_edge(5);
      chk("bounce_before", {a, b, c, d}, 9'b1001);
      wait_edge(1);
      chk("bounce_accept", {a, b, c, d, chg}, 9'b1011_0010);
      wait_edge(6);
      #1 chk("bounce_one_pulse", 9'(n_chg1 - n0), 9'd1);

      // all sixteen codes in counting order
      prev    = 4'b1011;
      exp_any = 0;
      n0      = n_any;
      for (int i = 0; i < 16; i++) begin
         apply(4'(i));
         if (4'(i) != prev) exp_any++;
         wait_edge(5);
         chk("code_hold", {a, b, c, d}, {5'b0, prev});
         wait_edge(1);
         chk("code_accept", {a, b, c, d, any_chg}, {4'(i), 4'(i) != prev});
         wait_edge(4);
         prev = 4'(i);
      end
      #1 chk("code_any_count", 9'(n_any - n0), 9'(exp_any));

      // reset in the middle of a count
      apply(4'b0000);
      wait_edge(10);
      apply(4'b1111);
      wait_edge(4);
      #3 rst = 1'b1;
      #1 chk("midreset_clear", {a, b, c, d, chg, any_chg}, 9'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      wait_edge(5);
      chk("reaccept_before", {a, b, c, d, chg}, 9'b0000_0000);
      wait_edge(1);
      chk("reaccept", {a, b, c, d, chg, any_chg}, 9'b1111_1111_1);
      wait_edge(1);
      chk("reaccept_end", {a, b, c, d, chg, any_chg}, 9'b1111_0000_0);

      // random holds, glitches and one reset, checked against the model
      for (int t = 0; t < 800; t++) begin
         int r;
         r = int'($urandom_range(0, 9));
         @(posedge clk);
         #2;
         if (t == 400) rst = 1'b1;
         else if (t == 402) rst = 1'b0;
         if (r == 0) sw_in = 4'($urandom);
         else if (r == 1) sw_in = sw_in ^ (4'b0001 << $urandom_range(0, 3));
      end
      wait_edge(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
